// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   the first key found, and shifts its hex code into a two-digit register
//   pair for a display multiplexer. A key is accepted once per
//   press/release; while it is held every other key is ignored.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   rows[3:0]    keypad row lines, active-low, asynchronous to clk
//   cols[3:0]    keypad column drive, active-low one-cold
//   digit_left   previously accepted key code
//   digit_right  most recently accepted key code
//   key_valid    one-cycle pulse on the cycle a key is accepted
//
// state      | meaning
// -----------+-------------------------------------------------------------
// SCAN       | drive each column for SCAN_TICKS cycles, look for a low row
// DEBOUNCE   | row must stay low DEBOUNCE_TICKS cycles to accept the key
// HELD       | key accepted; wait for its row to go high
// RELEASE_DB | row must stay high DEBOUNCE_TICKS cycles before rescanning

module keypad_scanner #(
   parameter int SCAN_TICKS     = 10000,
   parameter int DEBOUNCE_TICKS = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] digit_left,
   output logic [3:0] digit_right,
   output logic       key_valid
);

   localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
   localparam int CNT_W     = ($clog2(MAX_TICKS) > 20) ? $clog2(MAX_TICKS) : 20;
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      DEBOUNCE   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_col;
   logic [1:0]       r_row;
   logic [3:0]       r_cols;
   logic [3:0]       r_rows_meta;
   logic [3:0]       r_rows_sync;
   logic [3:0]       r_digit_left;
   logic [3:0]       r_digit_right;
   logic             r_key_valid;

   logic [1:0]       w_row_low_idx;
   logic             w_row_any_low;
   logic             w_sel_row_high;
   logic [1:0]       w_col_next;
   logic [3:0]       w_key_code;

   function automatic logic [3:0] col_drive(input logic [1:0] c);
      return ~(4'b0001 << c);
   endfunction

   // Keypad legend, indexed {row, col}.
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h2;
         4'd2:    code = 4'h3;
         4'd3:    code = 4'hA;
         4'd4:    code = 4'h4;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h6;
         4'd7:    code = 4'hB;
         4'd8:    code = 4'h7;
         4'd9:    code = 4'h8;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hC;
         4'd12:   code = 4'hE;
         4'd13:   code = 4'h0;
         4'd14:   code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Lowest-index low row wins when several rows are low at once.
   always_comb begin
      w_row_low_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!r_rows_sync[i]) w_row_low_idx = 2'(i);
      end
   end

   assign w_row_any_low  = (r_rows_sync != 4'b1111);
   assign w_sel_row_high = r_rows_sync[r_row];
   assign w_col_next     = r_col + 2'd1;
   assign w_key_code     = key_code(r_row, r_col);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= SCAN;
         r_cnt         <= '0;
         r_col         <= 2'd0;
         r_row         <= 2'd0;
         r_cols        <= 4'b1110;
         r_rows_meta   <= 4'b1111;
         r_rows_sync   <= 4'b1111;
         r_digit_left  <= 4'h0;
         r_digit_right <= 4'h0;
         r_key_valid   <= 1'b0;
      end else begin
         r_rows_meta <= rows;
         r_rows_sync <= r_rows_meta;
         r_key_valid <= 1'b0;

         case (r_state)
            SCAN: begin
               if (r_cnt == SCAN_LAST) begin
                  r_cnt <= '0;
                  if (w_row_any_low) begin
                     r_row   <= w_row_low_idx;
                     r_state <= DEBOUNCE;
                  end else begin
                     r_col  <= w_col_next;
                     r_cols <= col_drive(w_col_next);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            DEBOUNCE: begin
               if (w_sel_row_high) begin
                  r_cnt   <= '0;
                  r_col   <= w_col_next;
                  r_cols  <= col_drive(w_col_next);
                  r_state <= SCAN;
               end else if (r_cnt == DEB_LAST) begin
                  r_digit_left  <= r_digit_right;
                  r_digit_right <= w_key_code;
                  r_key_valid   <= 1'b1;
                  r_cnt         <= '0;
                  r_state       <= HELD;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            HELD: begin
               // Counter was cleared on entry and stays idle here.
               if (w_sel_row_high) begin
                  r_cnt   <= '0;
                  r_state <= RELEASE_DB;
               end
            end

            RELEASE_DB: begin
               if (!w_sel_row_high) begin
                  r_cnt   <= '0;
                  r_state <= HELD;
               end else if (r_cnt == DEB_LAST) begin
                  r_cnt   <= '0;
                  r_col   <= w_col_next;
                  r_cols  <= col_drive(w_col_next);
                  r_state <= SCAN;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            default: begin
               r_cnt   <= '0;
               r_state <= SCAN;
            end
         endcase
      end
   end

   assign cols        = r_cols;
   assign digit_left  = r_digit_left;
   assign digit_right = r_digit_right;
   assign key_valid   = r_key_valid;

endmodule
